// File: rtl/gamepad_pmod_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gamepad_pmod_pkg
//  Brief    : Shared constants, button bit positions and serializer FSM
//             state encoding for the Gamepad Pmod serial link.
//  Revision : 1.0  initial release
// ============================================================================
package gamepad_pmod_pkg;

    // Bits carried per controller and the word sent for an absent controller
    localparam int          PAD_BITS  = 12;
    localparam logic [11:0] PAD_EMPTY = 12'hFFF;

    // Button positions inside one 12-bit pad word (1 = pressed)
    localparam int B_IDX      = 11;
    localparam int Y_IDX      = 10;
    localparam int SELECT_IDX = 9;
    localparam int START_IDX  = 8;
    localparam int UP_IDX     = 7;
    localparam int DOWN_IDX   = 6;
    localparam int LEFT_IDX   = 5;
    localparam int RIGHT_IDX  = 4;
    localparam int A_IDX      = 3;
    localparam int X_IDX      = 2;
    localparam int L_IDX      = 1;
    localparam int R_IDX      = 0;

    // Serializer FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    // Word placed on the line for one pad: its buttons, or all-ones if absent
    function automatic logic [PAD_BITS-1:0] pad_word(input logic [PAD_BITS-1:0] i_buttons,
                                                     input logic                i_present);
        return i_present ? i_buttons : PAD_EMPTY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_pmod_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : gamepad_pmod_serializer_if
//  Brief    : Parallel button inputs and 3-wire serial/status outputs of the
//             Gamepad Pmod serializer. master = button source, slave = DUT.
//  Revision : 1.0  initial release
// ============================================================================
interface gamepad_pmod_serializer_if #(
    parameter int NUM_PADS = 1
) ();
    import gamepad_pmod_pkg::*;

    logic                         enable;
    logic [PAD_BITS*NUM_PADS-1:0] buttons;
    logic [NUM_PADS-1:0]          present;
    logic                         pmod_data;
    logic                         pmod_clk;
    logic                         pmod_latch;
    logic                         busy;
    logic                         frame_done;

    modport master (
        output enable, buttons, present,
        input  pmod_data, pmod_clk, pmod_latch, busy, frame_done
    );

    modport slave (
        input  enable, buttons, present,
        output pmod_data, pmod_clk, pmod_latch, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/gamepad_pmod_serializer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pmod_half_period_timer
//  Brief    : Phase timer for the serializer. A load restarts the count at 0;
//             o_tick flags the last cycle of a CLK_DIV-long phase, or of a
//             2*CLK_DIV-long phase when i_long was set at load.
//  Revision : 1.0  initial release
// ============================================================================
module pmod_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_load,
    input  wire logic i_long,
    output wire logic o_tick
);
    localparam int             CW         = $clog2(2*CLK_DIV);
    localparam logic [CW-1:0]  SHORT_LAST = CW'(CLK_DIV-1);
    localparam logic [CW-1:0]  LONG_LAST  = CW'(2*CLK_DIV-1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_long;

    assign o_tick = (r_cnt == (r_long ? LONG_LAST : SHORT_LAST));

    // Count from 0 after each load and hold at the terminal value until reloaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_long <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_long <= i_long;
        end else if (!o_tick) begin
            r_cnt  <= r_cnt + CNT_ONE;
        end
    end
endmodule
`default_nettype wire

// File: rtl/gamepad_pmod_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : gamepad_pmod_serializer
//  Brief    : Turns parallel button vectors into the Gamepad Pmod 3-wire
//             stream (data/clk/latch), MSB first, pad 0 last on the wire.
//  Revision : 1.0  initial release
// ============================================================================
module gamepad_pmod_serializer
    import gamepad_pmod_pkg::*;
#(
    parameter int NUM_PADS  = 1,
    parameter int CLK_DIV   = 4,
    parameter int FRAME_GAP = 64
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    gamepad_pmod_serializer_if.slave  bus
);
    localparam int            N        = PAD_BITS*NUM_PADS;
    localparam int            BW       = $clog2(N);
    localparam int            GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N-1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP-1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    state_t          r_state;
    logic [N-2:0]    r_shift;      // bits still to send after the one on the line
    logic [BW-1:0]   r_bit_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_pmod_data;
    logic            r_pmod_clk;
    logic            r_pmod_latch;
    logic            r_busy;
    logic            r_frame_done;

    logic [N-1:0]    w_frame;
    logic            w_tick;
    logic            w_tmr_load;
    logic            w_tmr_long;

    // Absent pads are replaced by the all-ones word before the snapshot
    generate
        for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
            assign w_frame[PAD_BITS*p +: PAD_BITS] =
                pad_word(bus.buttons[PAD_BITS*p +: PAD_BITS], bus.present[p]);
        end
    endgenerate

    // Timer restarts on every phase change; the latch phase is the long one
    assign w_tmr_load = (r_state == ST_IDLE) ||
                        (w_tick && ((r_state == ST_SHIFT_LO) ||
                                    (r_state == ST_SHIFT_HI) ||
                                    (r_state == ST_LATCH)));
    assign w_tmr_long = (r_state == ST_SHIFT_HI) && (r_bit_cnt == LAST_BIT);

    pmod_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_tmr_load),
        .i_long (w_tmr_long),
        .o_tick (w_tick)
    );

    // Frame sequencer: snapshot, shift out N bits, latch pulse, idle gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_pmod_data  <= 1'b0;
            r_pmod_clk   <= 1'b0;
            r_pmod_latch <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_pmod_data  <= 1'b0;
                    r_pmod_clk   <= 1'b0;
                    r_pmod_latch <= 1'b0;
                    r_busy       <= 1'b0;
                    if (bus.enable) begin
                        r_shift     <= w_frame[N-2:0];
                        r_bit_cnt   <= '0;
                        r_pmod_data <= w_frame[N-1];
                        r_busy      <= 1'b1;
                        r_state     <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tick) begin
                        r_pmod_clk <= 1'b1;
                        r_state    <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_tick) begin
                        r_pmod_clk <= 1'b0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_pmod_data  <= 1'b0;
                            r_pmod_latch <= 1'b1;
                            r_state      <= ST_LATCH;
                        end else begin
                            // Data only moves while the serial clock is low
                            r_bit_cnt   <= r_bit_cnt + BIT_ONE;
                            r_pmod_data <= r_shift[N-2];
                            r_shift     <= {r_shift[N-3:0], 1'b0};
                            r_state     <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_tick) begin
                        r_pmod_latch <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_gap_cnt    <= '0;
                        r_state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_ONE;
                    end
                end
                default: begin
                    r_pmod_data  <= 1'b0;
                    r_pmod_clk   <= 1'b0;
                    r_pmod_latch <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pmod_data  = r_pmod_data;
    assign bus.pmod_clk   = r_pmod_clk;
    assign bus.pmod_latch = r_pmod_latch;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire
